// File: rtl/spu_ma_stbuf_if.sv
// spu_ma_stbuf_if
//   Groups the sequencer-facing and LSU-facing signals of the MA store buffer.
//   The slave modport is the store buffer. The master modport is whatever sits
//   around it: the MA store sequencer plus the LSU (in the bench, one driver).
//
//   Handshake semantics:
//     spu_lsu_st_req is a valid that stays high, with data/pa held stable,
//     until the cycle lsu_grant is seen high. lsu_grant acts as a ready that
//     is only meaningful while spu_lsu_st_req is high. lsu_st_ack is a
//     completion pulse for the one granted store. stbuf_streq_ack is a
//     one-cycle pulse back to the sequencer in the cycle lsu_st_ack is seen.
//
//   Signals:
//     sequencer -> buffer : mast_stbuf_wen, stbuf_data, mpa_ld, mpa_in,
//                           mast_mpa_addrinc, mast_streq, mactl_abort
//     LSU -> buffer       : lsu_grant, lsu_st_ack
//     buffer -> LSU       : spu_lsu_st_req, spu_lsu_st_data, spu_lsu_st_pa
//     buffer -> sequencer : stbuf_streq_ack, stbuf_empty, stbuf_full, stbuf_err
//     debug               : dbg_state (request FSM state), dbg_pend
interface spu_ma_stbuf_if #(
    parameter int DATA_W = 64,
    parameter int PA_W   = 37
);
    logic              mast_stbuf_wen;
    logic [DATA_W-1:0] stbuf_data;
    logic              mpa_ld;
    logic [PA_W-1:0]   mpa_in;
    logic              mast_mpa_addrinc;
    logic              mast_streq;
    logic              mactl_abort;
    logic              lsu_grant;
    logic              lsu_st_ack;
    logic              spu_lsu_st_req;
    logic [DATA_W-1:0] spu_lsu_st_data;
    logic [PA_W-1:0]   spu_lsu_st_pa;
    logic              stbuf_streq_ack;
    logic              stbuf_empty;
    logic              stbuf_full;
    logic              stbuf_err;
    logic [1:0]        dbg_state;
    logic              dbg_pend;

    modport master (
        output mast_stbuf_wen, stbuf_data, mpa_ld, mpa_in, mast_mpa_addrinc,
               mast_streq, mactl_abort, lsu_grant, lsu_st_ack,
        input  spu_lsu_st_req, spu_lsu_st_data, spu_lsu_st_pa, stbuf_streq_ack,
               stbuf_empty, stbuf_full, stbuf_err, dbg_state, dbg_pend
    );

    modport slave (
        input  mast_stbuf_wen, stbuf_data, mpa_ld, mpa_in, mast_mpa_addrinc,
               mast_streq, mactl_abort, lsu_grant, lsu_st_ack,
        output spu_lsu_st_req, spu_lsu_st_data, spu_lsu_st_pa, stbuf_streq_ack,
               stbuf_empty, stbuf_full, stbuf_err, dbg_state, dbg_pend
    );
endinterface

// File: rtl/spu_ma_stbuf.sv
// spu_ma_stbuf
//   MA store buffer and LSU store-request issuer. Captures MA read data tagged
//   with the current 8-byte-aligned PA into a small FIFO, and on each sequencer
//   store request issues the head entry to the LSU, acknowledging the sequencer
//   once the LSU reports the store complete.
//
//   Ports:
//     rclk  - clock
//     reset - asynchronous reset, active-high
//     se    - scan enable; no functional effect
//     bus   - spu_ma_stbuf_if.slave (sequencer, LSU and debug signals)
module spu_ma_stbuf #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int PA_W   = 37
) (
    input  logic               rclk,
    input  logic               reset,
    input  logic               se,
    spu_ma_stbuf_if.slave      bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_ACK = 2'd2} state_t;

    state_t            state, state_nxt;
    logic              pend, pend_nxt;
    // Abort seen while a store was in flight: the eventual ack is absorbed.
    logic              abt_seen, abt_seen_nxt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [PA_W-1:0]   pa;
    logic              err;
    logic [DATA_W-1:0] st_data_q;
    logic [PA_W-1:0]   st_pa_q;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PA_W-1:0]   mem_pa   [DEPTH];

    logic empty, full, abort;
    logic push_ok, overflow, pop, load_head, err_req, ack;

    // Scan enable only reaches the flops in the physical netlist.
    logic unused_se;
    assign unused_se = se;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign abort = bus.mactl_abort;

    // A pop in the same cycle frees the slot, so a push into a full buffer
    // with a simultaneous pop is still accepted.
    assign push_ok  = bus.mast_stbuf_wen & ~abort & (~full | pop);
    assign overflow = bus.mast_stbuf_wen & ~abort & full & ~pop;

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        abt_seen_nxt = abt_seen;
        pop          = 1'b0;
        ack          = 1'b0;
        load_head    = 1'b0;
        err_req      = 1'b0;
        case (state)
            IDLE: begin
                if (abort) begin
                    pend_nxt = 1'b0;
                end else if ((bus.mast_streq | pend) & ~empty) begin
                    state_nxt = REQ;
                    pend_nxt  = 1'b0;
                    load_head = 1'b1;
                end else if (bus.mast_streq) begin
                    err_req = 1'b1;  // request with nothing to store
                end
            end
            REQ: begin
                if (abort) begin
                    state_nxt = IDLE;
                    pend_nxt  = 1'b0;
                end else begin
                    if (bus.lsu_grant) state_nxt = WAIT_ACK;
                    if (bus.mast_streq) begin
                        if (pend) err_req = 1'b1;
                        else      pend_nxt = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                if (abort) begin
                    pend_nxt     = 1'b0;
                    abt_seen_nxt = 1'b1;
                end else if (bus.mast_streq) begin
                    if (pend) err_req = 1'b1;
                    else      pend_nxt = 1'b1;
                end
                if (bus.lsu_st_ack) begin
                    state_nxt    = IDLE;
                    abt_seen_nxt = 1'b0;
                    // After an abort the in-flight entry was already flushed;
                    // anything now at the head is newer and must stay.
                    if (~abort & ~abt_seen) begin
                        pop = 1'b1;
                        ack = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= 1'b0;
            abt_seen  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pa        <= '0;
            err       <= 1'b0;
            st_data_q <= '0;
            st_pa_q   <= '0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            abt_seen <= abt_seen_nxt;

            if (bus.mpa_ld)                pa <= bus.mpa_in;
            else if (bus.mast_mpa_addrinc) pa <= pa + 1'b1;

            // mpa_ld wins over a new error raised in the same cycle.
            if (bus.mpa_ld)                  err <= 1'b0;
            else if (overflow | err_req)     err <= 1'b1;

            if (abort) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                if (push_ok & ~pop)      count <= count + 1'b1;
                else if (pop & ~push_ok) count <= count - 1'b1;
            end

            // Request payload is latched so it stays stable through REQ.
            if (load_head) begin
                st_data_q <= mem_data[rd_ptr];
                st_pa_q   <= mem_pa[rd_ptr];
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= bus.stbuf_data;
            mem_pa[wr_ptr]   <= pa;  // pre-increment PA
        end
    end

    assign bus.spu_lsu_st_req  = (state == REQ);
    assign bus.spu_lsu_st_data = st_data_q;
    assign bus.spu_lsu_st_pa   = st_pa_q;
    assign bus.stbuf_streq_ack = ack;
    assign bus.stbuf_empty     = empty;
    assign bus.stbuf_full      = full;
    assign bus.stbuf_err       = err;
    assign bus.dbg_state       = state;
    assign bus.dbg_pend        = pend;
endmodule

// File: tb/tb_spu_ma_stbuf.sv
// tb_spu_ma_stbuf
//   Bench for spu_ma_stbuf. Inputs are driven 1 time unit after the rising
//   edge; outputs are sampled on the falling edge. Pushed entries go into an
//   expected queue and are compared when the buffer raises a store request.
module tb_spu_ma_stbuf;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int PA_W   = 37;

    logic rclk = 1'b0;
    logic reset;
    logic se;

    spu_ma_stbuf_if #(.DATA_W(DATA_W), .PA_W(PA_W)) bus ();

    spu_ma_stbuf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PA_W(PA_W)) dut (
        .rclk  (rclk),
        .reset (reset),
        .se    (se),
        .bus   (bus)
    );

    always #5 rclk = ~rclk;

    logic [PA_W+DATA_W-1:0] exp_q[$];
    logic [PA_W-1:0]        pa_m;
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.mast_stbuf_wen   = 1'b0;
        bus.stbuf_data       = '0;
        bus.mpa_ld           = 1'b0;
        bus.mpa_in           = '0;
        bus.mast_mpa_addrinc = 1'b0;
        bus.mast_streq       = 1'b0;
        bus.mactl_abort      = 1'b0;
        bus.lsu_grant        = 1'b0;
        bus.lsu_st_ack       = 1'b0;
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d, input logic inc);
        bus.mast_stbuf_wen   = 1'b1;
        bus.stbuf_data       = d;
        bus.mast_mpa_addrinc = inc;
        if (exp_q.size() < DEPTH) exp_q.push_back({pa_m, d});
        if (inc) pa_m = pa_m + 1'b1;
        step();
        bus.mast_stbuf_wen   = 1'b0;
        bus.mast_mpa_addrinc = 1'b0;
    endtask

    task automatic do_inc();
        bus.mast_mpa_addrinc = 1'b1;
        pa_m = pa_m + 1'b1;
        step();
        bus.mast_mpa_addrinc = 1'b0;
    endtask

    task automatic load_pa(input logic [PA_W-1:0] v);
        bus.mpa_ld = 1'b1;
        bus.mpa_in = v;
        pa_m = v;
        step();
        bus.mpa_ld = 1'b0;
    endtask

    task automatic pulse_streq();
        bus.mast_streq = 1'b1;
        step();
        bus.mast_streq = 1'b0;
    endtask

    // Waits (bounded) for a store request and scores its payload.
    task automatic wait_req(input string tag);
        bit seen;
        logic [PA_W+DATA_W-1:0] e;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge rclk);
            if (bus.spu_lsu_st_req) seen = 1'b1;
            else step();
        end
        check({tag, "_req_seen"}, 128'(seen), 128'(1));
        if (seen) begin
            check({tag, "_q_nonempty"}, 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({tag, "_pa"},   128'(bus.spu_lsu_st_pa),   128'(e[PA_W+DATA_W-1:DATA_W]));
                check({tag, "_data"}, 128'(bus.spu_lsu_st_data), 128'(e[DATA_W-1:0]));
            end
            step();
        end
    endtask

    task automatic grant_it();
        bus.lsu_grant = 1'b1;
        step();
        bus.lsu_grant = 1'b0;
    endtask

    task automatic ack_it(input string tag, input logic exp_ack);
        bus.lsu_st_ack = 1'b1;
        @(negedge rclk);
        check({tag, "_streq_ack"}, 128'(bus.stbuf_streq_ack), 128'(exp_ack));
        check({tag, "_req_low"},   128'(bus.spu_lsu_st_req),  128'(0));
        step();
        bus.lsu_st_ack = 1'b0;
    endtask

    task automatic do_store(input string tag);
        pulse_streq();
        wait_req(tag);
        grant_it();
        ack_it(tag, 1'b1);
    endtask

    task automatic sample_flag(input string tag, input logic got_sel_dummy, input logic exp);
        check(tag, 128'(got_sel_dummy), 128'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        se = 1'b0;
        clear_inputs();
        pa_m = '0;
        reset = 1'b1;
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        reset = 1'b0;
        step();

        // Reset values
        @(negedge rclk);
        check("rst_req",   128'(bus.spu_lsu_st_req),  128'(0));
        check("rst_ack",   128'(bus.stbuf_streq_ack), 128'(0));
        check("rst_empty", 128'(bus.stbuf_empty),     128'(1));
        check("rst_full",  128'(bus.stbuf_full),      128'(0));
        check("rst_err",   128'(bus.stbuf_err),       128'(0));
        check("rst_data",  128'(bus.spu_lsu_st_data), 128'(0));
        check("rst_pa",    128'(bus.spu_lsu_st_pa),   128'(0));
        check("rst_state", 128'(bus.dbg_state),       128'(0));
        step();

        // 1: three pushes with addrinc between, three stores
        load_pa(37'h100);
        do_push(64'hD0D0_0000_0000_0000, 1'b0);
        do_inc();
        do_push(64'hD1D1_1111_1111_1111, 1'b0);
        do_inc();
        do_push(64'hD2D2_2222_2222_2222, 1'b0);
        do_store("t1_s0");
        do_store("t1_s1");
        do_store("t1_s2");
        @(negedge rclk);
        check("t1_empty", 128'(bus.stbuf_empty), 128'(1));
        check("t1_err",   128'(bus.stbuf_err),   128'(0));
        step();

        // 2: overflow
        for (int i = 0; i < 5; i++) begin
            d = {$urandom(), $urandom()};
            do_push(d, 1'b0);
            if (i == 3) begin
                @(negedge rclk);
                check("t2_full_after4", 128'(bus.stbuf_full), 128'(1));
                check("t2_err_after4",  128'(bus.stbuf_err),  128'(0));
                step();
            end
        end
        @(negedge rclk);
        check("t2_err_overflow", 128'(bus.stbuf_err),  128'(1));
        check("t2_still_full",   128'(bus.stbuf_full), 128'(1));
        step();
        load_pa(37'h200);
        @(negedge rclk);
        check("t2_err_cleared", 128'(bus.stbuf_err), 128'(0));
        step();
        for (int i = 0; i < DEPTH; i++) do_store($sformatf("t2_s%0d", i));
        @(negedge rclk);
        check("t2_empty", 128'(bus.stbuf_empty), 128'(1));
        step();

        // 3: request while empty
        pulse_streq();
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            check("t3_no_req", 128'(bus.spu_lsu_st_req), 128'(0));
            step();
        end
        @(negedge rclk);
        check("t3_err", 128'(bus.stbuf_err), 128'(1));
        step();
        load_pa(37'h300);
        @(negedge rclk);
        check("t3_err_cleared", 128'(bus.stbuf_err), 128'(0));
        step();

        // 4: pending request while in flight, then a second one -> error
        for (int i = 0; i < 3; i++) do_push({$urandom(), $urandom()}, 1'b1);
        pulse_streq();
        wait_req("t4_a");
        grant_it();
        pulse_streq();
        @(negedge rclk);
        check("t4_pend", 128'(bus.dbg_pend),  128'(1));
        check("t4_err0", 128'(bus.stbuf_err), 128'(0));
        step();
        pulse_streq();
        @(negedge rclk);
        check("t4_err_double", 128'(bus.stbuf_err), 128'(1));
        step();
        ack_it("t4_a", 1'b1);
        wait_req("t4_b");
        check("t4_pend_cleared", 128'(bus.dbg_pend), 128'(0));
        grant_it();
        ack_it("t4_b", 1'b1);
        do_store("t4_c");
        load_pa(37'h400);

        // 5a: abort while requesting (streq in the same cycle is ignored)
        do_push({$urandom(), $urandom()}, 1'b0);
        do_push({$urandom(), $urandom()}, 1'b0);
        pulse_streq();
        wait_req("t5_a");
        bus.mactl_abort = 1'b1;
        bus.mast_streq  = 1'b1;
        step();
        bus.mactl_abort = 1'b0;
        bus.mast_streq  = 1'b0;
        exp_q.delete();
        @(negedge rclk);
        check("t5a_req_drop", 128'(bus.spu_lsu_st_req),  128'(0));
        check("t5a_no_ack",   128'(bus.stbuf_streq_ack), 128'(0));
        check("t5a_empty",    128'(bus.stbuf_empty),     128'(1));
        check("t5a_pend",     128'(bus.dbg_pend),        128'(0));
        check("t5a_err",      128'(bus.stbuf_err),       128'(0));
        step();

        // 5b: abort while waiting for ack, push in the abort cycle dropped
        do_push({$urandom(), $urandom()}, 1'b0);
        pulse_streq();
        wait_req("t5_b");
        grant_it();
        bus.mactl_abort    = 1'b1;
        bus.mast_stbuf_wen = 1'b1;
        bus.stbuf_data     = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        bus.mactl_abort    = 1'b0;
        bus.mast_stbuf_wen = 1'b0;
        exp_q.delete();
        @(negedge rclk);
        check("t5b_empty", 128'(bus.stbuf_empty), 128'(1));
        check("t5b_state", 128'(bus.dbg_state),   128'(2));
        step();
        ack_it("t5b_absorb", 1'b0);
        @(negedge rclk);
        check("t5b_idle", 128'(bus.dbg_state), 128'(0));
        step();
        ack_it("t5b_stray", 1'b0);
        @(negedge rclk);
        check("t5b_empty2", 128'(bus.stbuf_empty), 128'(1));
        check("t5b_err",    128'(bus.stbuf_err),   128'(0));
        step();

        // 6: PA wrap, push+addrinc captures old PA, async reset mid-request
        load_pa({PA_W{1'b1}});
        do_push(64'h0123_4567_89AB_CDEF, 1'b1);
        do_push(64'hFEDC_BA98_7654_3210, 1'b0);
        do_store("t6_wrap_a");
        do_store("t6_wrap_b");
        do_push(64'h5555_AAAA_5555_AAAA, 1'b0);
        pulse_streq();
        wait_req("t6_rst");
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_req",   128'(bus.spu_lsu_st_req), 128'(0));
        check("t6_rst_empty", 128'(bus.stbuf_empty),    128'(1));
        check("t6_rst_data",  128'(bus.spu_lsu_st_data), 128'(0));
        exp_q.delete();
        pa_m = '0;
        @(negedge rclk);
        reset = 1'b0;
        step();
        ack_it("t6_stray", 1'b0);
        @(negedge rclk);
        check("t6_state", 128'(bus.dbg_state),   128'(0));
        check("t6_empty", 128'(bus.stbuf_empty), 128'(1));
        step();
        // PA pointer came back from reset at zero
        do_push(64'h1111_2222_3333_4444, 1'b0);
        do_store("t6_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
